// File: rtl/polymul_pkg.sv
// Shared definitions for the ternary polynomial multiplier.
// Contents:
//   state_t          - job FSM states (IDLE, COMPUTE, DONE)
//   MODE_NEGACYCLIC  - reduction by x^N+1 (wrapped terms change sign)
//   MODE_CYCLIC      - reduction by x^N-1 (wrapped terms keep sign)
//   cnt_width()      - bit width of the coefficient counter for length n
package polymul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic MODE_NEGACYCLIC = 1'b0;
    localparam logic MODE_CYCLIC     = 1'b1;

    // Counter must hold 0..n-1; n >= 2 keeps the result at least 1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ternary_polymul_if.sv
// Job/result bus of the ternary polynomial multiplier.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds valid and its payload stable until that
// edge; ready may be raised or lowered at any time and never depends on
// valid.
// Signals:
//   in_valid/in_ready  job handshake; payload in_mode, in_a, in_s_pos, in_s_neg
//   in_mode            0 = negacyclic (x^N+1), 1 = cyclic (x^N-1)
//   in_a               coefficient a_i at [i*Q +: Q]
//   in_s_pos/in_s_neg  bit j marks a +1 / -1 contribution to s_j
//   out_valid/out_ready result handshake; payload out_data (c_k at [k*Q +: Q])
// Modports: master = job source / result sink, slave = multiplier.
interface ternary_polymul_if #(
    parameter int N = 4,
    parameter int Q = 10
);
    logic           in_valid;
    logic           in_ready;
    logic           in_mode;
    logic [N*Q-1:0] in_a;
    logic [N-1:0]   in_s_pos;
    logic [N-1:0]   in_s_neg;
    logic           out_valid;
    logic           out_ready;
    logic [N*Q-1:0] out_data;

    modport master (
        output in_valid, in_mode, in_a, in_s_pos, in_s_neg, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_s_pos, in_s_neg, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ternary_dot.sv
// Combinational dot product of a Q-bit operand vector with a ternary vector.
// Ports:
//   rot  in  N*Q  operands, element j at [j*Q +: Q]
//   pos  in  N    bit j adds element j
//   neg  in  N    bit j subtracts element j (both bits set cancel)
//   dot  out Q    sum modulo 2^Q
module ternary_dot #(
    parameter int N = 4,
    parameter int Q = 10
) (
    input  logic [N*Q-1:0]       rot,
    input  logic [N-1:0]         pos,
    input  logic [N-1:0]         neg,
    output logic signed [Q-1:0]  dot
);

    always_comb begin
        dot = '0;
        for (int j = 0; j < N; j++) begin
            if (pos[j]) dot = dot + $signed(rot[j*Q +: Q]);
            if (neg[j]) dot = dot - $signed(rot[j*Q +: Q]);
        end
    end

endmodule

// File: rtl/ternary_polymul.sv
// Sequential multiplier of a dense polynomial a by a ternary polynomial s in
// Z_(2^Q)[x]/(x^N +/- 1), one output coefficient per COMPUTE cycle.
// Ports:
//   clk        clock
//   rst        synchronous, active-low reset
//   bus        ternary_polymul_if slave (job in, result out)
//   dbg_state  current FSM state
// The rotation register holds, for output index k, rot[j] = +/- a_(k-j mod N)
// with the wrap sign already applied, so every coefficient is a plain
// ternary dot product of rot with the secret masks.
module ternary_polymul
    import polymul_pkg::*;
#(
    parameter int N = 4,
    parameter int Q = 10
) (
    input  logic               clk,
    input  logic               rst,
    ternary_polymul_if.slave   bus,
    output state_t             dbg_state
);

    localparam int CW = cnt_width(N);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic [N-1:0]    pos_q, pos_d;
    logic [N-1:0]    neg_q, neg_d;
    logic [N*Q-1:0]  rot_q, rot_d;
    logic [N*Q-1:0]  out_q, out_d;
    logic signed [Q-1:0] dot;
    logic            accept;
    logic            out_fire;

    // Multiplication by sigma: negate for negacyclic, pass for cyclic.
    function automatic logic [Q-1:0] apply_sigma(input logic mode, input logic [Q-1:0] v);
        if (mode == MODE_NEGACYCLIC) return '0 - v;
        return v;
    endfunction

    ternary_dot #(.N(N), .Q(Q)) u_dot (
        .rot (rot_q),
        .pos (pos_q),
        .neg (neg_q),
        .dot (dot)
    );

    // in_ready is forced low while reset is held so no job slips in.
    assign bus.in_ready  = rst && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_q;
    assign dbg_state     = state_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        rot_d   = rot_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                    mode_d  = bus.in_mode;
                    pos_d   = bus.in_s_pos;
                    neg_d   = bus.in_s_neg;
                    rot_d[0 +: Q] = bus.in_a[0 +: Q];
                    for (int j = 1; j < N; j++) begin
                        rot_d[j*Q +: Q] = apply_sigma(bus.in_mode, bus.in_a[(N-j)*Q +: Q]);
                    end
                end
            end
            COMPUTE: begin
                out_d[int'(cnt_q)*Q +: Q] = dot;
                // Shift toward higher j; the element leaving the top wraps
                // past x^N and picks up sigma.
                for (int j = 1; j < N; j++) begin
                    rot_d[j*Q +: Q] = rot_q[(j-1)*Q +: Q];
                end
                rot_d[0 +: Q] = apply_sigma(mode_q, rot_q[(N-1)*Q +: Q]);
                if (cnt_q == CW'(N-1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_NEGACYCLIC;
            pos_q   <= '0;
            neg_q   <= '0;
            rot_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            rot_q   <= rot_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_ternary_polymul.sv
module tb_ternary_polymul;
    import polymul_pkg::*;

    localparam int N = 4;
    localparam int Q = 10;
    localparam int W = N * Q;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    ternary_polymul_if #(.N(N), .Q(Q)) bus ();

    ternary_polymul #(.N(N), .Q(Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        logic [W-1:0] r;
        r[0*Q +: Q] = c0[Q-1:0];
        r[1*Q +: Q] = c1[Q-1:0];
        r[2*Q +: Q] = c2[Q-1:0];
        r[3*Q +: Q] = c3[Q-1:0];
        return r;
    endfunction

    // c_k = sum_j s_j * a_(k-j mod N), wrapped terms negated in negacyclic mode.
    function automatic logic [W-1:0] ref_mul(input logic mode, input logic [W-1:0] a,
                                             input logic [N-1:0] pos, input logic [N-1:0] neg);
        logic [W-1:0] r;
        int av[N];
        int acc, d, term, s;
        for (int i = 0; i < N; i++) av[i] = int'(a[i*Q +: Q]);
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int j = 0; j < N; j++) begin
                d = k - j;
                if (d < 0) begin
                    d = d + N;
                    term = (mode == MODE_CYCLIC) ? av[d] : -av[d];
                end else begin
                    term = av[d];
                end
                s = int'(pos[j]) - int'(neg[j]);
                acc = acc + s * term;
            end
            r[k*Q +: Q] = acc[Q-1:0];
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_a      = '0;
        bus.in_s_pos  = '0;
        bus.in_s_neg  = '0;
        bus.out_ready = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge with
    // the inputs scrambled so late sampling would be visible.
    task automatic drive_job(input logic mode, input logic [W-1:0] a,
                             input logic [N-1:0] pos, input logic [N-1:0] neg, output bit ok);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_a     = a;
        bus.in_s_pos = pos;
        bus.in_s_neg = neg;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_mode  = ~mode;
        bus.in_a     = W'({$urandom(), $urandom()});
        bus.in_s_pos = N'($urandom());
        bus.in_s_neg = N'($urandom());
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_data !== '0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dbg_state); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic         mode_t[6];
        logic [W-1:0] a_t[6];
        logic [N-1:0] pos_t[6], neg_t[6];
        logic [W-1:0] exp_t[6];
        bit ok;
        int lat;
        mode_t[0] = MODE_NEGACYCLIC; a_t[0] = pack4(1,2,3,4); pos_t[0] = 4'b0001; neg_t[0] = 4'b0000; exp_t[0] = pack4(1,2,3,4);
        mode_t[1] = MODE_NEGACYCLIC; a_t[1] = pack4(1,2,3,4); pos_t[1] = 4'b0010; neg_t[1] = 4'b0000; exp_t[1] = pack4(1020,1,2,3);
        mode_t[2] = MODE_CYCLIC;     a_t[2] = pack4(1,2,3,4); pos_t[2] = 4'b0010; neg_t[2] = 4'b0000; exp_t[2] = pack4(4,1,2,3);
        mode_t[3] = MODE_NEGACYCLIC; a_t[3] = pack4(1,2,3,4); pos_t[3] = 4'b0000; neg_t[3] = 4'b0001; exp_t[3] = pack4(1023,1022,1021,1020);
        mode_t[4] = MODE_NEGACYCLIC; a_t[4] = pack4(1,2,3,4); pos_t[4] = 4'b1111; neg_t[4] = 4'b1111; exp_t[4] = pack4(0,0,0,0);
        mode_t[5] = MODE_CYCLIC;     a_t[5] = pack4(1023,1023,1023,1023); pos_t[5] = 4'b1111; neg_t[5] = 4'b0000; exp_t[5] = pack4(1020,1020,1020,1020);
        for (int t = 0; t < 6; t++) begin
            drive_job(mode_t[t], a_t[t], pos_t[t], neg_t[t], ok);
            wait_out(lat);
            total_cnt++; if (!ok || lat != N) $display("FAIL directed%0d_latency: got %0d accepted=%0b want %0d", t, lat, ok, N); else pass_cnt++;
            total_cnt++; if (bus.out_data !== exp_t[t]) $display("FAIL directed%0d_data: got %h want %h", t, bus.out_data, exp_t[t]); else pass_cnt++;
            handshake();
            total_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL directed%0d_release: out_valid=%b in_ready=%b want 0/1", t, bus.out_valid, bus.in_ready); else pass_cnt++;
            total_cnt++; if (bus.out_data !== exp_t[t]) $display("FAIL directed%0d_idle_hold: got %h want %h", t, bus.out_data, exp_t[t]); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic         mode;
        logic [W-1:0] a, exp;
        logic [N-1:0] pos, neg;
        bit ok;
        int lat;
        for (int t = 0; t < 24; t++) begin
            mode = 1'($urandom_range(0, 1));
            a    = W'({$urandom(), $urandom()});
            pos  = N'($urandom());
            neg  = N'($urandom());
            exp_q.push_back(ref_mul(mode, a, pos, neg));
            drive_job(mode, a, pos, neg, ok);
            wait_out(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            exp = exp_q.pop_front();
            total_cnt++; if (!ok || lat != N || bus.out_data !== exp || bus.out_valid !== 1'b1)
                $display("FAIL random%0d: got %h lat=%0d valid=%b want %h lat=%0d", t, bus.out_data, lat, bus.out_valid, exp, N); else pass_cnt++;
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a_a, a_b, exp_a, exp_b;
        logic [N-1:0] p_b, n_b;
        bit ok;
        int lat;
        a_a = W'({$urandom(), $urandom()});
        exp_a = ref_mul(MODE_NEGACYCLIC, a_a, 4'b1011, 4'b0110);
        drive_job(MODE_NEGACYCLIC, a_a, 4'b1011, 4'b0110, ok);
        wait_out(lat);
        total_cnt++; if (!ok || bus.out_data !== exp_a) $display("FAIL bp_first_data: got %h want %h", bus.out_data, exp_a); else pass_cnt++;
        a_b = W'({$urandom(), $urandom()});
        p_b = N'($urandom());
        n_b = N'($urandom());
        exp_b = ref_mul(MODE_CYCLIC, a_b, p_b, n_b);
        bus.in_valid = 1'b1; bus.in_mode = MODE_CYCLIC; bus.in_a = a_b; bus.in_s_pos = p_b; bus.in_s_neg = n_b;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_a || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: valid=%b data=%h in_ready=%b want 1/%h/0", i, bus.out_valid, bus.out_data, bus.in_ready, exp_a); else pass_cnt++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total_cnt++; if (bus.in_ready !== 1'b1 || dbg_state !== IDLE) $display("FAIL bp_idle_after_hs: in_ready=%b state=%0d want 1/IDLE", bus.in_ready, dbg_state); else pass_cnt++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total_cnt++; if (dbg_state !== COMPUTE) $display("FAIL bp_second_accept: state=%0d want COMPUTE", dbg_state); else pass_cnt++;
        wait_out(lat);
        total_cnt++; if (lat != N || bus.out_data !== exp_b) $display("FAIL bp_second_data: got %h lat=%0d want %h lat=%0d", bus.out_data, lat, exp_b, N); else pass_cnt++;
        handshake();
    endtask

    task automatic test_reset_mid_job();
        logic [W-1:0] a, exp;
        bit ok, saw_valid;
        int lat;
        a = W'({$urandom(), $urandom()});
        drive_job(MODE_CYCLIC, a, 4'b0111, 4'b1000, ok);
        repeat (2) @(negedge clk);
        total_cnt++; if (dbg_state !== COMPUTE) $display("FAIL rstmid_in_compute: state=%0d want COMPUTE", dbg_state); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
            $display("FAIL rstmid_cleared: data=%h valid=%b in_ready=%b want 0/0/0", bus.out_data, bus.out_valid, bus.in_ready); else pass_cnt++;
        rst = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        total_cnt++; if (saw_valid || bus.in_ready !== 1'b1) $display("FAIL rstmid_aborted: saw_valid=%b in_ready=%b want 0/1", saw_valid, bus.in_ready); else pass_cnt++;
        a = W'({$urandom(), $urandom()});
        exp = ref_mul(MODE_NEGACYCLIC, a, 4'b1100, 4'b0011);
        drive_job(MODE_NEGACYCLIC, a, 4'b1100, 4'b0011, ok);
        wait_out(lat);
        total_cnt++; if (!ok || lat != N || bus.out_data !== exp) $display("FAIL rstmid_fresh_job: got %h lat=%0d want %h lat=%0d", bus.out_data, lat, exp, N); else pass_cnt++;
        handshake();
    endtask

    task automatic test_back_to_back();
        int cyc, acc_prev, sent, done;
        bit load;
        logic [W-1:0] exp;
        cyc = 0; acc_prev = -1; sent = 0; done = 0; load = 1'b1;
        bus.out_ready = 1'b1;
        while (done < 5 && cyc < 300) begin
            if (load) begin
                load = 1'b0;
                if (sent < 5) begin
                    bus.in_valid = 1'b1;
                    bus.in_mode  = 1'($urandom_range(0, 1));
                    bus.in_a     = W'({$urandom(), $urandom()});
                    bus.in_s_pos = N'($urandom());
                    bus.in_s_neg = N'($urandom());
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_mul(bus.in_mode, bus.in_a, bus.in_s_pos, bus.in_s_neg));
                if (acc_prev >= 0) begin
                    total_cnt++; if (cyc - acc_prev != N + 2) $display("FAIL b2b_interval%0d: got %0d want %0d", sent, cyc - acc_prev, N + 2); else pass_cnt++;
                end
                acc_prev = cyc;
                sent++;
                load = 1'b1;
            end
            if (bus.out_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total_cnt++; if (bus.out_data !== exp) $display("FAIL b2b_data%0d: got %h want %h", done, bus.out_data, exp); else pass_cnt++;
                done++;
            end
            @(negedge clk);
            cyc++;
        end
        total_cnt++; if (done != 5) $display("FAIL b2b_count: got %0d results want 5", done); else pass_cnt++;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_job();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
